// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register file defaults and dump FSM states.
package mips_pkg;

  localparam int REG_WIDTH_D     = 32;
  localparam int REG_ADDR_BITS_D = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump sequencer: walks every register index once per request.
module regfile_dump_fsm
  import mips_pkg::*;
#(
  parameter int REG_ADDR_BITS = REG_ADDR_BITS_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dump_start,
  input  logic                     dump_ready,
  output logic                     dump_busy,
  output logic                     dump_valid,
  output logic                     dump_done,
  output logic [REG_ADDR_BITS-1:0] index
);

  localparam logic [REG_ADDR_BITS-1:0] LAST = '1;

  dump_state_t               state, state_n;
  logic [REG_ADDR_BITS-1:0] index_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_n;
      index <= index_n;
    end
  end

  // Terminal compare on LAST stops the index before it can wrap.
  always_comb begin
    state_n    = state;
    index_n    = index;
    dump_busy  = 1'b0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dump_start) begin
          state_n = SEND;
          index_n = '0;
        end
      end
      SEND: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (index == LAST) state_n = DONE;
          else index_n = index + 1'b1;
        end
      end
      DONE: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/register_file_dbg.sv
// Two-read/one-write register file with write-first bypass,
// optional hard-wired zero register and a handshaked dump port.
module register_file_dbg
  import mips_pkg::*;
#(
  parameter int REG_WIDTH     = REG_WIDTH_D,
  parameter int REG_ADDR_BITS = REG_ADDR_BITS_D,
  parameter int ZERO_REG      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_w,
  input  logic [REG_ADDR_BITS-1:0] addr_reg_w,
  input  logic [REG_WIDTH-1:0]     reg_w_data_in,
  input  logic [REG_ADDR_BITS-1:0] addr_reg_a,
  input  logic [REG_ADDR_BITS-1:0] addr_reg_b,
  output logic [REG_WIDTH-1:0]     reg_a_data_out,
  output logic [REG_WIDTH-1:0]     reg_b_data_out,
  input  logic                     dump_start,
  output logic                     dump_busy,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [REG_ADDR_BITS-1:0] dump_addr,
  output logic [REG_WIDTH-1:0]     dump_data,
  output logic                     dump_done
);

  localparam int DEPTH = 2 ** REG_ADDR_BITS;

  logic [REG_WIDTH-1:0]     regs [DEPTH];
  logic                     wr_ok;
  logic [REG_ADDR_BITS-1:0] dump_idx;
  logic [REG_WIDTH-1:0]     rd_a, rd_b, rd_d;

  // Writes to r0 are dropped, so r0 stays 0 and bypass never hits it.
  assign wr_ok = write_w &&
                 !((ZERO_REG != 0) && (addr_reg_w == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[addr_reg_w] <= reg_w_data_in;
    end
  end

  always_comb begin
    rd_a = regs[addr_reg_a];
    rd_b = regs[addr_reg_b];
    rd_d = regs[dump_idx];
    if (wr_ok && addr_reg_w == addr_reg_a) rd_a = reg_w_data_in;
    if (wr_ok && addr_reg_w == addr_reg_b) rd_b = reg_w_data_in;
    if (wr_ok && addr_reg_w == dump_idx)   rd_d = reg_w_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a_data_out <= '0;
      reg_b_data_out <= '0;
    end else begin
      reg_a_data_out <= rd_a;
      reg_b_data_out <= rd_b;
    end
  end

  regfile_dump_fsm #(
    .REG_ADDR_BITS(REG_ADDR_BITS)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .index      (dump_idx)
  );

  assign dump_addr = dump_valid ? dump_idx : '0;
  assign dump_data = dump_valid ? rd_d : '0;

endmodule

// File: doc/register_file_dbg.md
# register_file_dbg

Parametrised general-purpose register file for the pipelined MIPS core, replacing the single-mode register bank. It provides two registered read ports with write-first bypass and an optional hard-wired zero register. It also has a third, handshaked debug-dump port that streams every register, in index order, to the debug unit (UART framer) on request. It sits between the decode stage (reads), the write-back stage (writes) and the debug unit.

## Interface
Parameters:
- REG_WIDTH, 32, data width of each register (≥1)
- REG_ADDR_BITS, 5, address width; depth = 2**REG_ADDR_BITS
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- write_w  in  1  write enable for the write port
- addr_reg_w  in  REG_ADDR_BITS  write address
- reg_w_data_in  in  REG_WIDTH  write data
- addr_reg_a  in  REG_ADDR_BITS  read port A address
- addr_reg_b  in  REG_ADDR_BITS  read port B address
- reg_a_data_out  out  REG_WIDTH  read port A data, registered
- reg_b_data_out  out  REG_WIDTH  read port B data, registered
- dump_start  in  1  one-cycle request to begin a dump
- dump_busy  out  1  high from the cycle after accepted start until dump ends
- dump_valid  out  1  dump_data/dump_addr hold a valid entry
- dump_ready  in  1  consumer accepts the entry when dump_valid & dump_ready
- dump_addr  out  REG_ADDR_BITS  index of the current entry
- dump_data  out  REG_WIDTH  contents of register dump_addr
- dump_done  out  1  one-cycle pulse after the last entry is accepted

## Operation
- Reset: all registers cleared to 0. reg_a/b_data_out = 0, dump_busy = dump_valid = dump_done = 0, dump_addr = 0, dump_data = 0. FSM goes to IDLE. Reset takes effect immediately, including mid-dump.
- Write: when write_w=1, reg[addr_reg_w] <= reg_w_data_in on the rising edge. When ZERO_REG=1 and addr_reg_w=0, the write is discarded.
- Reads are unconditional every cycle. Unlike the old bank, a concurrent write does not stall port A.
- Each read port output <= reg[addr]. Bypass applies when write_w=1, addr_reg_w=addr, and the address is not the zero register (if ZERO_REG=1); the output then gets reg_w_data_in (write-first).
- With ZERO_REG=1, a read of address 0 yields 0.
- Ports A and B are independent and may use the same address.
- Dump FSM states:
  - IDLE: dump_start=1 -> SEND, with index=0.
  - SEND: dump_valid=1. dump_addr=index. dump_data is the current content of reg[index], with the same bypass and zero rules as the read ports, evaluated combinationally each cycle.
  - SEND on handshake (valid & ready): if index = 2**REG_ADDR_BITS-1 -> DONE; else index+1.
  - DONE: dump_done=1 for one cycle -> IDLE.
- dump_busy=1 in SEND and DONE.
- dump_start in SEND/DONE is ignored; there is no queueing.
- The dump runs concurrently with normal reads and writes. It is not a snapshot: each entry reflects contents in its handshake cycle.
- dump_ready low holds dump_addr/dump_data stable, except when a write to that same index changes the data.

## Timing
- Read latency: 1 cycle (address at edge N -> data valid after edge N).
- Write visible to a read in the same cycle via bypass.
- Dump: first dump_valid in the cycle after dump_start is sampled.
- With dump_ready held high, a full dump takes depth cycles in SEND plus 1 in DONE. Default depth is 32, so 33 cycles after start.
- Index width is REG_ADDR_BITS. The terminal compare prevents wrap-around, so no entry is sent twice.

## Structure
- Shared package (mips_pkg): FSM state encoding (IDLE, SEND, DONE) and default REG_WIDTH/REG_ADDR_BITS constants.
- One sub-module: regfile_dump_fsm (state, index, handshake, done pulse). It drives an internal dump read address into the storage array.
- Storage, read ports and bypass logic stay in the top module.

## Test plan
- Reset then read all 32 addresses on A and B -> every output 0.
- Write 0xDEADBEEF to r5, then read r5 on A and B next cycle -> both 0xDEADBEEF 1 cycle later. Writing 0x12345678 to r0 with ZERO_REG=1 -> r0 reads 0. With ZERO_REG=0 -> r0 reads 0x12345678.
- Bypass: in one cycle, write r7=0xA5A5A5A5 and read r7 on A, r8 on B -> A=0xA5A5A5A5, B=old r8.
- Preload rN=N*0x11, pulse dump_start, hold dump_ready high:
  - 32 handshakes with dump_addr 0..31 and data N*0x11 (0 at r0);
  - dump_done on cycle 33, then dump_busy low.
- Dump with dump_ready toggling 1-0 and a mid-dump start pulse:
  - entries held stable while ready is low;
  - the extra start is ignored;
  - a write to r10 before its entry is dumped -> new value reported.
- Assert rst while in SEND at index 12 -> all outputs 0 immediately. A new dump_start after release begins at index 0.
